// File: rtl/color_pkg.sv
`default_nettype none
// color_pkg -- color type, channel bit positions and fader states shared by the lighting pipeline. Rev 1.0
package color_pkg;
  localparam int CH_W = 8;
  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  typedef logic [23:0] color_t;

  typedef enum logic [0:0] {
    FADER_IDLE = 1'b0,
    FADER_FADE = 1'b1
  } fader_state_e;
endpackage
`default_nettype wire

// File: rtl/channel_ramp.sv
`default_nettype none
// channel_ramp -- one bounded step of an 8-bit channel toward its target, saturating at the target. Rev 1.0
module channel_ramp
  import color_pkg::*;
#(
  parameter int STEP_SIZE = 1
) (
  input  logic [CH_W-1:0] cur,
  input  logic [CH_W-1:0] tgt,
  output logic [CH_W-1:0] next_val,
  output logic            equal
);

  localparam logic [CH_W-1:0] STEP = CH_W'(STEP_SIZE);

  logic [CH_W-1:0] up_gap;
  logic [CH_W-1:0] dn_gap;

  assign up_gap = tgt - cur;
  assign dn_gap = cur - tgt;

  // Only move by STEP when the remaining gap exceeds it, so the sum never wraps.
  always_comb begin
    next_val = tgt;
    if (tgt > cur) begin
      if (up_gap > STEP) next_val = cur + STEP;
    end else if (dn_gap > STEP) begin
      next_val = cur - STEP;
    end
  end

  assign equal = (next_val == tgt);

endmodule
`default_nettype wire

// File: rtl/color_fader.sv
`default_nettype none
// color_fader -- ramps a registered 24-bit color toward a loaded target, one bounded step
// per channel every STEP_CYCLES clocks; busy while fading, one-cycle done on completion. Rev 1.0
module color_fader
  import color_pkg::*;
#(
  parameter int          STEP_CYCLES = 1000,
  parameter int          STEP_SIZE   = 1,
  parameter logic [23:0] RESET_COLOR = 24'h000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] target_i,
  input  logic        load_i,
  output logic [23:0] color_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int             PW   = $clog2(STEP_CYCLES);
  localparam logic [PW-1:0]  LAST = PW'(STEP_CYCLES - 1);

  fader_state_e  state;
  fader_state_e  state_n;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_n;
  color_t        tgt;
  color_t        tgt_n;
  color_t        color_n;
  color_t        step_color;
  logic          done_n;
  logic          r_eq;
  logic          g_eq;
  logic          b_eq;
  logic          step_now;
  logic          all_eq;

  channel_ramp #(.STEP_SIZE(STEP_SIZE)) u_ramp_r (
    .cur      (color_o[R_HI:R_LO]),
    .tgt      (tgt[R_HI:R_LO]),
    .next_val (step_color[R_HI:R_LO]),
    .equal    (r_eq)
  );

  channel_ramp #(.STEP_SIZE(STEP_SIZE)) u_ramp_g (
    .cur      (color_o[G_HI:G_LO]),
    .tgt      (tgt[G_HI:G_LO]),
    .next_val (step_color[G_HI:G_LO]),
    .equal    (g_eq)
  );

  channel_ramp #(.STEP_SIZE(STEP_SIZE)) u_ramp_b (
    .cur      (color_o[B_HI:B_LO]),
    .tgt      (tgt[B_HI:B_LO]),
    .next_val (step_color[B_HI:B_LO]),
    .equal    (b_eq)
  );

  assign step_now = (presc == LAST);
  assign all_eq   = r_eq & g_eq & b_eq;
  assign busy_o   = (state == FADER_FADE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= FADER_IDLE;
      presc   <= '0;
      tgt     <= RESET_COLOR;
      color_o <= RESET_COLOR;
      done_o  <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      tgt     <= tgt_n;
      color_o <= color_n;
      done_o  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    tgt_n   = tgt;
    color_n = color_o;
    done_n  = 1'b0;
    case (state)
      FADER_IDLE: begin
        if (load_i) begin
          tgt_n = target_i;
          if (target_i == color_o) begin
            done_n = 1'b1;
          end else begin
            state_n = FADER_FADE;
            presc_n = '0;
          end
        end
      end
      FADER_FADE: begin
        presc_n = step_now ? '0 : presc + 1'b1;
        if (step_now) color_n = step_color;
        // A retarget landing on a step edge lets that step use the old target;
        // completion is then judged against the new target on the next step.
        if (load_i) begin
          tgt_n = target_i;
          if (!step_now && (target_i == color_o)) begin
            state_n = FADER_IDLE;
            done_n  = 1'b1;
          end
        end else if (step_now && all_eq) begin
          state_n = FADER_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = FADER_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_color_fader.sv
`default_nettype none
// tb_color_fader -- two faders (step 1 / reset 000000 and step 4 / reset 123456) share
// directed and random stimulus and are compared every cycle against a behavioural model.
module tb_color_fader;
  localparam int          SC  = 4;
  localparam int          SS0 = 1;
  localparam int          SS1 = 4;
  localparam logic [23:0] RC0 = 24'h000000;
  localparam logic [23:0] RC1 = 24'h123456;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [23:0] target = 24'h0;
  logic [23:0] col0, col1;
  logic        busy0, busy1, done0, done1;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  logic [23:0] m_col[2];
  logic [23:0] m_tgt[2];
  bit          m_busy[2];
  bit          m_done[2];
  int          m_cnt[2];
  logic [23:0] m_before;
  bit          m_stepped;

  color_fader #(.STEP_CYCLES(SC), .STEP_SIZE(SS0), .RESET_COLOR(RC0)) dut0 (
    .clk_i(clk), .rst_i(rst), .target_i(target), .load_i(load),
    .color_o(col0), .busy_o(busy0), .done_o(done0)
  );

  color_fader #(.STEP_CYCLES(SC), .STEP_SIZE(SS1), .RESET_COLOR(RC1)) dut1 (
    .clk_i(clk), .rst_i(rst), .target_i(target), .load_i(load),
    .color_o(col1), .busy_o(busy1), .done_o(done1)
  );

  always #5 clk = ~clk;

  function automatic int ss(input int k);
    return (k == 0) ? SS0 : SS1;
  endfunction

  function automatic logic [23:0] rc(input int k);
    return (k == 0) ? RC0 : RC1;
  endfunction

  // Each channel moves toward its target by at most s, landing exactly on it.
  function automatic logic [23:0] step_color(input logic [23:0] c, input logic [23:0] t, input int s);
    logic [23:0] r;
    for (int ch = 0; ch < 3; ch++) begin
      int cv, tv, d;
      cv = int'(c[8*ch +: 8]);
      tv = int'(t[8*ch +: 8]);
      d  = tv - cv;
      if (d > s)       cv = cv + s;
      else if (d < -s) cv = cv - s;
      else             cv = tv;
      r[8*ch +: 8] = cv[7:0];
    end
    return r;
  endfunction

  // Model: count clocks since the fade began; every SC-th one applies a step.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_col[k] = rc(k); m_tgt[k] = rc(k);
        m_busy[k] = 1'b0; m_done[k] = 1'b0; m_cnt[k] = 0;
      end else begin
        m_done[k] = 1'b0;
        if (!m_busy[k]) begin
          if (load) begin
            m_tgt[k] = target;
            if (target == m_col[k]) m_done[k] = 1'b1;
            else begin m_busy[k] = 1'b1; m_cnt[k] = 0; end
          end
        end else begin
          m_before  = m_col[k];
          m_cnt[k]  = m_cnt[k] + 1;
          m_stepped = (m_cnt[k] % SC) == 0;
          if (m_stepped) m_col[k] = step_color(m_col[k], m_tgt[k], ss(k));
          if (load) begin
            m_tgt[k] = target;
            if (!m_stepped && target == m_before) begin m_busy[k] = 1'b0; m_done[k] = 1'b1; end
          end else if (m_stepped && m_col[k] == m_tgt[k]) begin
            m_busy[k] = 1'b0; m_done[k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("color0", 32'(col0), 32'(m_col[0]));
      chk("busy0",  32'(busy0), 32'(m_busy[0]));
      chk("done0",  32'(done0), 32'(m_done[0]));
      chk("color1", 32'(col1), 32'(m_col[1]));
      chk("busy1",  32'(busy1), 32'(m_busy[1]));
      chk("done1",  32'(done1), 32'(m_done[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [23:0] t);
    target = t;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy0 && !busy1) break;
      tick();
    end
    chk("idle_wait", 32'({busy0, busy1}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int kind;
    logic [23:0] t;

    // Reset
    rst = 1'b1;
    tick(); tick();
    chk("rst_color0", 32'(col0), 32'h000000);
    chk("rst_busy0",  32'(busy0), 32'd0);
    chk("rst_done0",  32'(done0), 32'd0);
    chk("rst_color1", 32'(col1), 32'h123456);
    chk("model_rst_color1", 32'(m_col[1]), 32'h123456);
    cmp_en = 1'b1;
    rst = 1'b0;

    // Ramp up 000000 -> 030000
    do_load(24'h030000);
    chk("ramp_busy_e0", 32'(busy0), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4 || i == 8) begin
        chk("ramp_r", 32'(col0[23:16]), 32'(i / 4));
        chk("ramp_nodone", 32'(done0), 32'd0);
      end
      if (i == 12) begin
        chk("ramp_final", 32'(col0), 32'h030000);
        chk("ramp_done", 32'(done0), 32'd1);
        chk("ramp_idle", 32'(busy0), 32'd0);
        chk("model_ramp_final", 32'(m_col[0]), 32'h030000);
      end
    end
    tick();
    chk("ramp_done_drop", 32'(done0), 32'd0);

    // Saturation on the STEP_SIZE=4 instance
    do_load(24'h000000);
    wait_idle(2000);
    do_load(24'h0A00FF);
    nd = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (done1) nd++;
      if (i == 4)   chk("sat_r4",  32'(col1[23:16]), 32'h04);
      if (i == 8)   chk("sat_r8",  32'(col1[23:16]), 32'h08);
      if (i == 12)  chk("sat_r10", 32'(col1[23:16]), 32'h0A);
      if (i == 252) chk("sat_b252", 32'(col1[7:0]), 32'hFC);
      if (i == 256) begin
        chk("sat_final", 32'(col1), 32'h0A00FF);
        chk("sat_done",  32'(done1), 32'd1);
      end
    end
    chk("sat_done_count", 32'(nd), 32'd1);
    wait_idle(2000);

    // Retarget mid-fade
    do_load(24'h000000);
    wait_idle(2000);
    do_load(24'h100000);
    for (int i = 1; i <= 8; i++) tick();
    chk("rt_r2", 32'(col0[23:16]), 32'h02);
    do_load(24'h000000);
    nd = 0;
    for (int i = 10; i <= 20; i++) begin
      tick();
      if (done0) nd++;
      if (i == 12) chk("rt_r1", 32'(col0[23:16]), 32'h01);
      if (i == 16) begin
        chk("rt_r0", 32'(col0), 32'h000000);
        chk("rt_done", 32'(done0), 32'd1);
      end
    end
    chk("rt_done_count", 32'(nd), 32'd1);

    // No-op load
    wait_idle(2000);
    do_load(24'h000000);
    chk("noop_busy", 32'(busy0), 32'd0);
    chk("noop_done", 32'(done0), 32'd1);
    chk("model_noop_done", 32'(m_done[0]), 32'd1);
    tick();
    chk("noop_done_drop", 32'(done0), 32'd0);

    // Reset mid-fade
    do_load(24'hFF0000);
    for (int i = 1; i <= 20; i++) tick();
    chk("rmf_r5", 32'(col0[23:16]), 32'h05);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmf_color0", 32'(col0), 32'h000000);
    chk("rmf_busy0",  32'(busy0), 32'd0);
    chk("rmf_done0",  32'(done0), 32'd0);
    chk("rmf_color1", 32'(col1), 32'h123456);
    do_load(24'h030000);
    for (int i = 1; i <= 4; i++) tick();
    chk("rmf_restart_r1", 32'(col0[23:16]), 32'h01);

    // Random loads, retargets and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        kind = int'($urandom_range(0, 3));
        case (kind)
          0:       t = 24'($urandom);
          1:       t = m_col[0];
          2:       t = {5'd0, 3'($urandom), 5'd0, 3'($urandom), 5'd0, 3'($urandom)};
          default: t = m_col[0] ^ {5'd0, 3'($urandom), 5'd0, 3'($urandom), 5'd0, 3'($urandom)};
        endcase
        target = t;
        load   = 1'b1;
      end
      tick();
      load = 1'b0;
      rst  = 1'b0;
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/color_fader.md
# color_fader

Smooth color-transition stage between the controller and `color_mixer`. Accepts a 24-bit target color (0xRRGGBB) with a load strobe and ramps its registered output color toward the target, one bounded step per channel every `STEP_CYCLES` clocks. Its `color_o` drives `color_mixer.color_i` directly, so color changes fade instead of jumping. Reports `busy_o` while ramping and a one-cycle `done_o` when the output equals the target.

## Interface
- `STEP_CYCLES`, default 1000: clocks between ramp steps; legal range ≥ 2.
- `STEP_SIZE`, default 1: maximum per-channel change per step; legal range 1..255.
- `RESET_COLOR`, default 24'h000000: value of `color_o` after reset.

- `clk_i`  input  1  clock; one clock domain, all logic on its rising edge.
- `rst_i`  input  1  reset; synchronous, active-high.
- `target_i`  input  24  target color {R[23:16], G[15:8], B[7:0]}, sampled only when `load_i`=1.
- `load_i`  input  1  load strobe; latches `target_i` on a rising edge.
- `color_o`  output  24  current faded color (registered), to `color_mixer`.
- `busy_o`  output  1  high while in FADE.
- `done_o`  output  1  one-cycle pulse when a fade completes.

## Operation
- Two states:
  - IDLE: `busy_o`=0.
  - FADE: `busy_o`=1.
- Reset, taking priority over everything:
  - `color_o`=RESET_COLOR, target register=RESET_COLOR.
  - `busy_o`=0, `done_o`=0, prescaler=0.
  - State=IDLE.
- IDLE, `load_i`=1:
  - Latch `target_i`.
  - If `target_i` == `color_o`: stay IDLE and pulse `done_o` next cycle.
  - Otherwise: go to FADE and clear the prescaler.
- FADE:
  - Prescaler counts 0..STEP_CYCLES-1.
  - On the edge where it equals STEP_CYCLES-1, apply a step to all three channels at once and wrap the prescaler to 0.
- Per-channel step rule, with d = target − current as 9-bit signed:
  - |d| ≤ STEP_SIZE: current := target (saturate, never overshoot).
  - d > STEP_SIZE: current += STEP_SIZE.
  - d < −STEP_SIZE: current −= STEP_SIZE.
  - Channel values never leave 0..255.
- Completion: if a step makes all three channels equal the target, go to IDLE and assert `done_o` on that same edge.
- `load_i` during FADE (retarget):
  - Latch the new target.
  - `color_o` and the prescaler are unchanged, so step cadence continues.
  - No `done_o` for the abandoned target.
- Retarget equal to current `color_o` during FADE: go to IDLE next edge with a `done_o` pulse.
- `load_i` and a step edge in the same cycle: the step uses the OLD target, then the new target is latched; completion is evaluated against the new target next step.
- `done_o` is never high for more than one cycle. It is only asserted after a load.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Load sampled at edge 0:
  - `busy_o`=1 after edge 0.
  - First `color_o` change after edge STEP_CYCLES.
  - Step k lands after edge k·STEP_CYCLES.
- Final step edge: `color_o`=target, `busy_o`=0 and `done_o`=1 are all visible in the same cycle. `done_o` drops after the next edge.
- Fade duration = ceil(max channel |d| / STEP_SIZE) · STEP_CYCLES clocks.
- Reset mid-fade: outputs return to reset values after the reset edge, with no `done_o`.

## Structure
- Shared package `color_pkg`:
  - Channel bit-range constants (R 23:16, G 15:8, B 7:0).
  - 24-bit color type.
  - Same definitions reused by `controller` and `color_mixer`.
- Sub-module `channel_ramp`:
  - Combinational 8-bit step unit (current, target, STEP_SIZE → next, equal).
  - Instantiated 3×.
- Top `color_fader` holds the FSM, prescaler, target register and output register.
- Expected size about 150–220 lines.

## Test plan
All scenarios use STEP_CYCLES=4 and STEP_SIZE=1 unless noted.
- Reset: hold `rst_i` for 2 cycles → `color_o`=000000, `busy_o`=0, `done_o`=0. Repeat with RESET_COLOR=123456 → `color_o`=123456.
- Ramp up: load 030000 from 000000 → R = 1, 2, 3 after edges 4, 8, 12. `busy_o` high from edge 0 through the cycle before edge 12. `done_o` single pulse in the cycle where R=3.
- Saturation, STEP_SIZE=4: load 0A00FF from 000000 →
  - R sequence 4, 8, 10.
  - B sequence 4, 8, …, 252, 255 after 64 steps.
  - `done_o` only after B reaches 255. No overshoot on any channel.
- Retarget: load 100000; after R=2, load 000000 → R = 1, 0 on continued cadence. Exactly one `done_o`, at R=0.
- No-op load: with `color_o`=000000, load 000000 → `busy_o` stays 0, `done_o`=1 for one cycle after the load edge.
- Reset mid-fade: assert `rst_i` at R=5 during a fade toward FF0000 → `color_o`=000000 and `busy_o`=0 next cycle, no `done_o`. A new load then starts cleanly from 000000.
